// File: rtl/register_file_pkg.sv
// Shared defaults, typedefs and constants for the register file.
package register_file_pkg;

  localparam int WIDTH_DEF      = 16;
  localparam int DEPTH_DEF      = 8;
  localparam int ADDR_WIDTH_DEF = 3;

  typedef logic [ADDR_WIDTH_DEF-1:0] addr_t;
  typedef logic [WIDTH_DEF-1:0]      word_t;

  localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/register_file_cell.sv
// One storage word: rising-edge enabled register with synchronous reset.
module register_file_cell
  import register_file_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             w,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (w) begin
      q <= d;
    end
  end

endmodule

// File: rtl/register_file.sv
// Register file: one write port, two registered read ports, register 0 hardwired to zero.
// Define REGISTER_FILE_BYPASS_EN to forward same-cycle write data to the read ports.
module register_file
  import register_file_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  w,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      d,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr_a,
  input  logic [ADDR_WIDTH-1:0] raddr_b,
  output logic [WIDTH-1:0]      qa,
  output logic [WIDTH-1:0]      qb,
  output logic                  qvalid
);

  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [WIDTH-1:0] rd_a_p0;
  logic [WIDTH-1:0] rd_b_p0;
  logic [WIDTH-1:0] qa_p1;
  logic [WIDTH-1:0] qb_p1;
  logic             vld_p1;

  assign regs[ZERO_REG] = '0;

  for (genvar i = 1; i < DEPTH; i++) begin : g_cell
    logic we;
    assign we = w && (waddr == ADDR_WIDTH'(i));

    register_file_cell #(.WIDTH(WIDTH)) u_cell (
      .clk   (clk),
      .reset (reset),
      .w     (we),
      .d     (d),
      .q     (regs[i])
    );
  end

  // Stage p0: read muxes (with optional write-data forwarding)
  always_comb begin
    rd_a_p0 = regs[raddr_a];
    rd_b_p0 = regs[raddr_b];
`ifdef REGISTER_FILE_BYPASS_EN
    if (w && (waddr == raddr_a) && (raddr_a != ZERO_ADDR)) begin
      rd_a_p0 = d;
    end
    if (w && (waddr == raddr_b) && (raddr_b != ZERO_ADDR)) begin
      rd_b_p0 = d;
    end
`endif
  end

  // Stage p1: registered read data and valid
  always_ff @(posedge clk) begin
    if (reset) begin
      qa_p1  <= '0;
      qb_p1  <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= re;
      if (re) begin
        qa_p1 <= rd_a_p0;
        qb_p1 <= rd_b_p0;
      end
    end
  end

  assign qa     = qa_p1;
  assign qb     = qb_p1;
  assign qvalid = vld_p1;

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file (default parameters).
module tb_register_file;

  logic        clk = 1'b0;
  logic        reset;
  logic        w;
  logic [2:0]  waddr;
  logic [15:0] d;
  logic        re;
  logic [2:0]  raddr_a;
  logic [2:0]  raddr_b;
  logic [15:0] qa;
  logic [15:0] qb;
  logic        qvalid;

  int total = 0;
  int bad   = 0;

  register_file dut (
    .clk     (clk),
    .reset   (reset),
    .w       (w),
    .waddr   (waddr),
    .d       (d),
    .re      (re),
    .raddr_a (raddr_a),
    .raddr_b (raddr_b),
    .qa      (qa),
    .qb      (qb),
    .qvalid  (qvalid)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [15:0] same_cycle_exp;
`ifdef REGISTER_FILE_BYPASS_EN
    same_cycle_exp = 16'h2222;
`else
    same_cycle_exp = 16'h1111;
`endif

    reset = 1'b1; w = 1'b0; waddr = '0; d = '0; re = 1'b0; raddr_a = '0; raddr_b = '0;
    step();
    step();
    chk("rst_qa", 32'(qa), 32'h0);
    chk("rst_qb", 32'(qb), 32'h0);
    chk("rst_qvalid", 32'(qvalid), 32'h0);

    // basic write then read, reg0 on port B
    reset = 1'b0;
    w = 1'b1; waddr = 3'd3; d = 16'hA5A5;
    step();
    w = 1'b0; re = 1'b1; raddr_a = 3'd3; raddr_b = 3'd0;
    step();
    chk("rd3_qa", 32'(qa), 32'hA5A5);
    chk("rd3_qb", 32'(qb), 32'h0000);
    chk("rd3_qvalid", 32'(qvalid), 32'h1);

    // write to register 0 is ignored
    re = 1'b0; w = 1'b1; waddr = 3'd0; d = 16'hFFFF;
    step();
    w = 1'b0; re = 1'b1; raddr_a = 3'd0;
    step();
    chk("r0_qa", 32'(qa), 32'h0000);
    // same-cycle write/read of register 0 still returns zero
    w = 1'b1; waddr = 3'd0; d = 16'hFFFF; raddr_a = 3'd0; raddr_b = 3'd0;
    step();
    chk("r0_same_qa", 32'(qa), 32'h0000);
    chk("r0_same_qb", 32'(qb), 32'h0000);

    // same-cycle write/read of the same nonzero address
    re = 1'b0; w = 1'b1; waddr = 3'd5; d = 16'h1111;
    step();
    w = 1'b1; waddr = 3'd5; d = 16'h2222; re = 1'b1; raddr_a = 3'd5; raddr_b = 3'd3;
    step();
    chk("same_qa", 32'(qa), 32'(same_cycle_exp));
    chk("diff_qb", 32'(qb), 32'hA5A5);
    w = 1'b0; raddr_a = 3'd5;
    step();
    chk("after_qa", 32'(qa), 32'h2222);

    // fill 1..7 then stream reads with re held high
    re = 1'b0;
    for (int i = 1; i < 8; i++) begin
      w = 1'b1; waddr = 3'(i); d = 16'(i);
      step();
    end
    w = 1'b0; re = 1'b1;
    for (int k = 0; k < 7; k++) begin
      raddr_a = 3'(k + 1); raddr_b = 3'(7 - k);
      step();
      chk($sformatf("sweep%0d_qa", k), 32'(qa), 32'(k + 1));
      chk($sformatf("sweep%0d_qb", k), 32'(qb), 32'(7 - k));
      chk($sformatf("sweep%0d_qvalid", k), 32'(qvalid), 32'h1);
    end
    raddr_a = 3'd4; raddr_b = 3'd4;
    step();
    chk("eq_qa", 32'(qa), 32'h4);
    chk("eq_qb", 32'(qb), 32'h4);

    // hold behaviour with re low
    re = 1'b0; w = 1'b1; waddr = 3'd2; d = 16'h00FF;
    step();
    w = 1'b0; re = 1'b1; raddr_a = 3'd2; raddr_b = 3'd7;
    step();
    chk("hold_pre_qa", 32'(qa), 32'h00FF);
    re = 1'b0;
    for (int c = 0; c < 3; c++) begin
      raddr_a = 3'(c + 4); raddr_b = 3'(c + 1);
      step();
      chk($sformatf("hold%0d_qa", c), 32'(qa), 32'h00FF);
      chk($sformatf("hold%0d_qb", c), 32'(qb), 32'h7);
      chk($sformatf("hold%0d_qvalid", c), 32'(qvalid), 32'h0);
    end

    // read followed by reset; reset beats same-cycle write and read
    re = 1'b1; raddr_a = 3'd2; raddr_b = 3'd2;
    step();
    chk("prerst_qvalid", 32'(qvalid), 32'h1);
    reset = 1'b1; w = 1'b1; waddr = 3'd6; d = 16'hBEEF; re = 1'b1; raddr_a = 3'd2; raddr_b = 3'd6;
    step();
    chk("rst2_qa", 32'(qa), 32'h0);
    chk("rst2_qb", 32'(qb), 32'h0);
    chk("rst2_qvalid", 32'(qvalid), 32'h0);

    // first edge after reset accepts write and read
    reset = 1'b0; w = 1'b1; waddr = 3'd1; d = 16'h1234; re = 1'b1; raddr_a = 3'd2; raddr_b = 3'd6;
    step();
    chk("post_qa", 32'(qa), 32'h0000);
    chk("post_qb", 32'(qb), 32'h0000);
    chk("post_qvalid", 32'(qvalid), 32'h1);
    w = 1'b0; raddr_a = 3'd1; raddr_b = 3'd7;
    step();
    chk("post_wr_qa", 32'(qa), 32'h1234);
    chk("post_wr_qb", 32'(qb), 32'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
